chacha_stream: RTL and testbench
================================

Name: chacha_stream

Overview:
- Host-side initiator for the byte-wide chacha core. It drives the core's write strobes, data_in, rd_blk and hold pins.
- Loads key, nonce and counter into the core, waits for blk_ready, and bursts each 64-byte keystream block into a local buffer.
- XORs the buffered keystream with a valid/ready plaintext byte stream to produce ciphertext.
- Auto-increments the 64-bit block counter and regenerates a block each time the buffer drains.

Parameters:
- KEY_BYTES, 32, key bytes written per block
- NNC_BYTES, 8, nonce bytes written per block
- CTR_BYTES, 8, counter bytes written per block
- BLK_BYTES, 64, keystream bytes read per block

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- start  in  1  pulse: latch key/nonce/ctr and begin keystream generation
- key_in  in  256  key; byte i = key_in[8i+7:8i]
- nonce_in  in  64  nonce; byte i = nonce_in[8i+7:8i]
- ctr_in  in  64  initial block counter; written LSB first
- pause  in  1  passed to core_hold
- pt_data  in  8  plaintext byte
- pt_valid  in  1  plaintext valid
- pt_ready  out  1  plaintext accepted when pt_valid & pt_ready
- ct_data  out  8  ciphertext byte (registered)
- ct_valid  out  1  ciphertext valid
- ct_ready  in  1  downstream ready
- busy  out  1  high in any state except IDLE
- ctr_wrap  out  1  sticky; set when the counter wraps 2^64-1 -> 0; cleared by start or reset
- core_wr_key, core_wr_nnc, core_wr_ctr  out  1 each  core write strobes
- core_rd_blk  out  1  core read strobe
- core_hold  out  1  core pause
- core_blk_ready  in  1  core block available
- core_din  out  8  bytes to core data_in
- core_dout  in  8  bytes from core data_out

Behaviour:
- Reset: state IDLE; every output 0; buffer invalid; ctr and ctr_wrap 0; ct_valid 0.
- core_hold = pause, combinational.
- States: IDLE, LD_KEY, LD_NNC, LD_CTR, WAIT_BLK, READ, DRAIN. Byte counter idx is 6 bits.
- start, accepted in any state: latch key/nonce/ctr_in, clear ctr_wrap, invalidate buffer, idx=0, go to LD_KEY.
  - Abort mid-READ is safe because core writes take priority over core reads.
- LD_KEY: 32 cycles, core_din = key byte idx.
  - core_wr_key is high only on the idx=0 cycle.
  - After idx=31, go to LD_NNC with idx=0.
- LD_NNC: same pattern, 8 bytes, wr_nnc on the first cycle only.
- LD_CTR: same pattern, 8 bytes, wr_ctr on the first cycle only, then go to WAIT_BLK.
- No idle cycles between LD_KEY, LD_NNC and LD_CTR. The sequence is exactly 48 cycles.
- Strobes outside their first cycle are 0. core_din is 0 outside the LD states.
- WAIT_BLK: on core_blk_ready=1, assert core_rd_blk for 1 cycle and go to READ.
  - blk_ready is ignored in every other state.
- READ: core_dout is valid combinationally from the rd_blk cycle.
  - Capture buf[idx] = core_dout on each of 64 consecutive cycles, idx 0..63; the rd_blk cycle is capture 0.
  - After capture 63: buf_valid=1, rd_ptr=0, ctr <= ctr+1 (64-bit wrap; set ctr_wrap on wrap), go to DRAIN.
- DRAIN:
  - pt_ready = buf_valid & (~ct_valid | ct_ready).
  - On accept: ct_data <= pt_data ^ buf[rd_ptr], ct_valid <= 1, rd_ptr++.
  - ct_valid clears on ct_ready when there is no new accept.
  - On the accept at rd_ptr=63: buf_valid=0, idx=0, go to LD_KEY.
  - All 48 bytes are rewritten each block, since core state is consumed by the output.
- Throughput: one byte/cycle while draining. No prefetch; a block refill stalls pt_ready.
- pt_ready is 0 in all non-DRAIN states. An outstanding ct byte still completes on ct_ready.
- pause high holds only the core computation. Loads, reads and drain proceed.
- Reset mid-operation: immediate return to IDLE with all outputs 0.

Decomposition:
- Package chacha_stream_pkg holds:
  - state encoding localparams
  - byte counts 32/8/8/64
  - last-index constants 31/7/7/63
- One sub-module, chacha_ks_buffer:
  - 64x8 register file with write port (we, waddr, wdata)
  - async read port (raddr -> rdata)
  - valid flag with set and clear inputs

Test Plan:
- Zero key/nonce/ctr, start, pt all 0x00 for 64 bytes, core instance attached -> ct begins 76 b8 e0 ad a0 f1 3d 90, and 64 bytes match the ChaCha20 zero-vector block 0.
- Same setup, 128 bytes -> bytes 64..127 equal block 1 (9f 07 e7 be 55 51 38 7a ...); a second 48-byte load shows counter bytes 01 00..00 on core_din.
- Load trace: after start, check 48 cycles of core_din = key[0..31], nonce[0..7], ctr[0..7], with wr_key/wr_nnc/wr_ctr each high exactly one cycle, at cycles 0, 32 and 40.
- ct_ready held 0 for 10 cycles mid-drain -> pt_ready 0, ct_data stable; on release, no byte is lost or duplicated, verified with 64 bytes of pattern 0xA5.
- ctr_in=FFFF_FFFF_FFFF_FFFF, one block drained -> ctr_wrap=1 and the next load writes counter 00 x8; start clears ctr_wrap.
- start asserted mid-READ (capture 20) -> LD_KEY the next cycle with wr_key=1; rst_n=0 mid-drain -> all outputs 0 the next cycle.

Source files
------------

// File: rtl/chacha_stream_pkg.sv
// chacha_stream_pkg: shared constants for the chacha host-side stream initiator.
//   - FSM state encoding
//   - byte counts of each load/read phase and their last byte index
//   - byte-select helper for the key/nonce/counter shift-out
package chacha_stream_pkg;

    localparam int KEY_NB = 32;
    localparam int NNC_NB = 8;
    localparam int CTR_NB = 8;
    localparam int BLK_NB = 64;

    localparam logic [5:0] KEY_LAST = 6'd31;
    localparam logic [5:0] NNC_LAST = 6'd7;
    localparam logic [5:0] CTR_LAST = 6'd7;
    localparam logic [5:0] BLK_LAST = 6'd63;

    typedef logic [2:0] state_t;

    localparam state_t S_IDLE     = 3'd0;
    localparam state_t S_LD_KEY   = 3'd1;
    localparam state_t S_LD_NNC   = 3'd2;
    localparam state_t S_LD_CTR   = 3'd3;
    localparam state_t S_WAIT_BLK = 3'd4;
    localparam state_t S_READ     = 3'd5;
    localparam state_t S_DRAIN    = 3'd6;

    // Byte i of a little-endian 256-bit vector; narrower fields are zero-extended by the caller.
    function automatic logic [7:0] pick_byte(input logic [255:0] v, input logic [4:0] i);
        return v[{i, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/chacha_ks_buffer.sv
// chacha_ks_buffer: one keystream block of storage.
//   clk, rst_n            clock, synchronous active-low reset (clears valid only)
//   we, waddr, wdata      write port
//   raddr -> rdata        asynchronous read port
//   set_valid, clr_valid  valid flag control; clear wins when both are high
//   valid                 block holds unconsumed keystream
module chacha_ks_buffer
    import chacha_stream_pkg::*;
#(
    parameter int DEPTH = BLK_NB,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic [AW-1:0] raddr,
    output logic [7:0]    rdata,
    input  logic          set_valid,
    input  logic          clr_valid,
    output logic          valid
);

    logic [7:0] mem [DEPTH];

    // Contents are meaningless until valid is set, so the array itself is not reset.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

    always_ff @(posedge clk) begin
        if (!rst_n)         valid <= 1'b0;
        else if (clr_valid) valid <= 1'b0;
        else if (set_valid) valid <= 1'b1;
    end

endmodule

// File: rtl/chacha_stream.sv
// chacha_stream: drives a byte-wide chacha core and XORs its keystream onto a byte stream.
//   clk, rst_n                    clock, synchronous active-low reset
//   start, key_in, nonce_in,      latch key material and (re)start keystream generation
//   ctr_in
//   pause                         forwarded to core_hold
//   pt_data/pt_valid/pt_ready     plaintext in
//   ct_data/ct_valid/ct_ready     ciphertext out (registered)
//   busy, ctr_wrap                status
//   core_*                        chacha core pins
// Each block: 48 load cycles (key, nonce, counter), wait for blk_ready, 64 read cycles,
// then drain 64 bytes of plaintext before the next block is fetched.
module chacha_stream
    import chacha_stream_pkg::*;
#(
    parameter int KEY_BYTES = KEY_NB,
    parameter int NNC_BYTES = NNC_NB,
    parameter int CTR_BYTES = CTR_NB,
    parameter int BLK_BYTES = BLK_NB
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [8*KEY_BYTES-1:0] key_in,
    input  logic [8*NNC_BYTES-1:0] nonce_in,
    input  logic [8*CTR_BYTES-1:0] ctr_in,
    input  logic                   pause,
    input  logic [7:0]             pt_data,
    input  logic                   pt_valid,
    output logic                   pt_ready,
    output logic [7:0]             ct_data,
    output logic                   ct_valid,
    input  logic                   ct_ready,
    output logic                   busy,
    output logic                   ctr_wrap,
    output logic                   core_wr_key,
    output logic                   core_wr_nnc,
    output logic                   core_wr_ctr,
    output logic                   core_rd_blk,
    output logic                   core_hold,
    input  logic                   core_blk_ready,
    output logic [7:0]             core_din,
    input  logic [7:0]             core_dout
);

    state_t                 state, state_nxt;
    logic [5:0]             idx;
    logic [5:0]             rd_ptr;
    logic [8*KEY_BYTES-1:0] key_r;
    logic [8*NNC_BYTES-1:0] nnc_r;
    logic [8*CTR_BYTES-1:0] ctr;

    logic       buf_valid;
    logic [7:0] ks_byte;
    logic       cap_en;
    logic [5:0] cap_addr;
    logic       cap_last;
    logic       accept;
    logic       drain_done;

    assign core_hold = pause;

    // The rd_blk cycle in WAIT_BLK is capture 0; READ covers captures 1..63.
    assign cap_en     = (state == S_WAIT_BLK && core_blk_ready) || state == S_READ;
    assign cap_addr   = (state == S_READ) ? idx : 6'd0;
    assign cap_last   = (state == S_READ) && idx == BLK_LAST;
    assign accept     = pt_valid & pt_ready;
    assign drain_done = accept && rd_ptr == BLK_LAST;

    chacha_ks_buffer #(.DEPTH(BLK_BYTES)) u_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .we        (cap_en),
        .waddr     (cap_addr),
        .wdata     (core_dout),
        .raddr     (rd_ptr),
        .rdata     (ks_byte),
        .set_valid (cap_last),
        .clr_valid (start | drain_done),
        .valid     (buf_valid)
    );

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_nxt = state;
        if (start) begin
            state_nxt = S_LD_KEY;
        end else begin
            case (state)
                S_IDLE:     state_nxt = S_IDLE;
                S_LD_KEY:   if (idx == KEY_LAST) state_nxt = S_LD_NNC;
                S_LD_NNC:   if (idx == NNC_LAST) state_nxt = S_LD_CTR;
                S_LD_CTR:   if (idx == CTR_LAST) state_nxt = S_WAIT_BLK;
                S_WAIT_BLK: if (core_blk_ready)  state_nxt = S_READ;
                S_READ:     if (cap_last)        state_nxt = S_DRAIN;
                // Core state is consumed by the output, so every block reloads all 48 bytes.
                S_DRAIN:    if (drain_done)      state_nxt = S_LD_KEY;
                default:                         state_nxt = S_IDLE;
            endcase
        end
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        core_wr_key = 1'b0;
        core_wr_nnc = 1'b0;
        core_wr_ctr = 1'b0;
        core_rd_blk = 1'b0;
        core_din    = 8'd0;
        pt_ready    = 1'b0;
        busy        = state != S_IDLE;
        case (state)
            S_LD_KEY: begin
                core_wr_key = idx == 6'd0;
                core_din    = pick_byte(key_r, idx[4:0]);
            end
            S_LD_NNC: begin
                core_wr_nnc = idx == 6'd0;
                core_din    = pick_byte({192'd0, nnc_r}, {2'b00, idx[2:0]});
            end
            S_LD_CTR: begin
                core_wr_ctr = idx == 6'd0;
                core_din    = pick_byte({192'd0, ctr}, {2'b00, idx[2:0]});
            end
            S_WAIT_BLK: core_rd_blk = core_blk_ready;
            S_DRAIN:    pt_ready    = buf_valid & (~ct_valid | ct_ready);
            default: ;
        endcase
    end

    // ---------------- datapath ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx      <= 6'd0;
            rd_ptr   <= 6'd0;
            key_r    <= '0;
            nnc_r    <= '0;
            ctr      <= '0;
            ctr_wrap <= 1'b0;
        end else if (start) begin
            key_r    <= key_in;
            nnc_r    <= nonce_in;
            ctr      <= ctr_in;
            ctr_wrap <= 1'b0;
            idx      <= 6'd0;
        end else begin
            case (state)
                S_LD_KEY:   idx <= (idx == KEY_LAST) ? 6'd0 : idx + 6'd1;
                S_LD_NNC:   idx <= (idx == NNC_LAST) ? 6'd0 : idx + 6'd1;
                S_LD_CTR:   idx <= (idx == CTR_LAST) ? 6'd0 : idx + 6'd1;
                S_WAIT_BLK: if (core_blk_ready) idx <= 6'd1;
                S_READ: begin
                    if (cap_last) begin
                        idx    <= 6'd0;
                        rd_ptr <= 6'd0;
                        ctr    <= ctr + 1'b1;
                        if (&ctr) ctr_wrap <= 1'b1;
                    end else begin
                        idx <= idx + 6'd1;
                    end
                end
                S_DRAIN: begin
                    if (accept)     rd_ptr <= rd_ptr + 6'd1;
                    if (drain_done) idx    <= 6'd0;
                end
                default: ;
            endcase
        end
    end

    // An outstanding ciphertext byte is independent of the FSM and completes on ct_ready.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ct_data  <= 8'd0;
            ct_valid <= 1'b0;
        end else if (accept) begin
            ct_data  <= pt_data ^ ks_byte;
            ct_valid <= 1'b1;
        end else if (ct_ready) begin
            ct_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_chacha_stream.sv
module tb_chacha_stream;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [255:0] key_in;
    logic [63:0]  nonce_in;
    logic [63:0]  ctr_in;
    logic         pause = 1'b0;
    logic [7:0]   pt_data;
    logic         pt_valid;
    logic         pt_ready;
    logic [7:0]   ct_data;
    logic         ct_valid;
    logic         ct_ready = 1'b1;
    logic         busy, ctr_wrap;
    logic         core_wr_key, core_wr_nnc, core_wr_ctr, core_rd_blk, core_hold;
    logic         core_blk_ready;
    logic [7:0]   core_din, core_dout;

    always #5 clk = ~clk;

    chacha_stream dut (
        .clk(clk), .rst_n(rst_n), .start(start), .key_in(key_in), .nonce_in(nonce_in),
        .ctr_in(ctr_in), .pause(pause), .pt_data(pt_data), .pt_valid(pt_valid),
        .pt_ready(pt_ready), .ct_data(ct_data), .ct_valid(ct_valid), .ct_ready(ct_ready),
        .busy(busy), .ctr_wrap(ctr_wrap), .core_wr_key(core_wr_key), .core_wr_nnc(core_wr_nnc),
        .core_wr_ctr(core_wr_ctr), .core_rd_blk(core_rd_blk), .core_hold(core_hold),
        .core_blk_ready(core_blk_ready), .core_din(core_din), .core_dout(core_dout)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // ---------------- ChaCha20 reference (64-bit nonce, 64-bit counter) ----------------
    function automatic logic [31:0] rotl(input logic [31:0] v, input int n);
        return (v << n) | (v >> (32 - n));
    endfunction

    function automatic logic [127:0] qr(input logic [31:0] a_i, b_i, c_i, d_i);
        logic [31:0] a, b, c, d;
        a = a_i; b = b_i; c = c_i; d = d_i;
        a = a + b; d = rotl(d ^ a, 16);
        c = c + d; b = rotl(b ^ c, 12);
        a = a + b; d = rotl(d ^ a, 8);
        c = c + d; b = rotl(b ^ c, 7);
        return {a, b, c, d};
    endfunction

    function automatic logic [511:0] chacha_block(input logic [255:0] k, input logic [63:0] n,
                                                  input logic [63:0] c);
        logic [31:0]  s [16];
        logic [31:0]  x [16];
        logic [511:0] r;
        s[0] = 32'h61707865; s[1] = 32'h3320646e; s[2] = 32'h79622d32; s[3] = 32'h6b206574;
        for (int i = 0; i < 8; i++) s[4+i] = k[32*i +: 32];
        s[12] = c[31:0]; s[13] = c[63:32]; s[14] = n[31:0]; s[15] = n[63:32];
        x = s;
        for (int rd = 0; rd < 10; rd++) begin
            {x[0], x[4], x[8],  x[12]} = qr(x[0], x[4], x[8],  x[12]);
            {x[1], x[5], x[9],  x[13]} = qr(x[1], x[5], x[9],  x[13]);
            {x[2], x[6], x[10], x[14]} = qr(x[2], x[6], x[10], x[14]);
            {x[3], x[7], x[11], x[15]} = qr(x[3], x[7], x[11], x[15]);
            {x[0], x[5], x[10], x[15]} = qr(x[0], x[5], x[10], x[15]);
            {x[1], x[6], x[11], x[12]} = qr(x[1], x[6], x[11], x[12]);
            {x[2], x[7], x[8],  x[13]} = qr(x[2], x[7], x[8],  x[13]);
            {x[3], x[4], x[9],  x[14]} = qr(x[3], x[4], x[9],  x[14]);
        end
        for (int i = 0; i < 16; i++) r[32*i +: 32] = x[i] + s[i];
        return r;
    endfunction

    // ---------------- core model: captures loads, serves one block per load ----------------
    logic [255:0] cm_key;
    logic [63:0]  cm_nnc, cm_ctr;
    logic [511:0] cm_blk;
    logic [6:0]   rd_i;
    logic         cm_ready, cm_rd, cm_pend;
    int           ld_mode, ld_cnt, cm_dly;
    logic [63:0]  ld_ctr_q [$];

    assign core_blk_ready = cm_ready;
    assign core_dout      = cm_blk[{rd_i[5:0], 3'b000} +: 8];

    always @(posedge clk) begin
        if (!rst_n) begin
            ld_mode <= 0; ld_cnt <= 0; cm_ready <= 1'b0; cm_rd <= 1'b0;
            cm_pend <= 1'b0; cm_dly <= 0; rd_i <= 7'd0;
        end else begin
            if (core_wr_key)      begin ld_mode <= 1; ld_cnt <= 1; cm_key[7:0] <= core_din; end
            else if (core_wr_nnc) begin ld_mode <= 2; ld_cnt <= 1; cm_nnc[7:0] <= core_din; end
            else if (core_wr_ctr) begin ld_mode <= 3; ld_cnt <= 1; cm_ctr[7:0] <= core_din; end
            else if (ld_mode == 1) begin
                cm_key[8*ld_cnt +: 8] <= core_din; ld_cnt <= ld_cnt + 1;
                if (ld_cnt == 31) ld_mode <= 0;
            end else if (ld_mode == 2) begin
                cm_nnc[8*ld_cnt +: 8] <= core_din; ld_cnt <= ld_cnt + 1;
                if (ld_cnt == 7) ld_mode <= 0;
            end else if (ld_mode == 3) begin
                cm_ctr[8*ld_cnt +: 8] <= core_din; ld_cnt <= ld_cnt + 1;
                if (ld_cnt == 7) begin ld_mode <= 0; cm_pend <= 1'b1; end
            end

            if (cm_pend) begin
                cm_pend <= 1'b0;
                cm_blk  <= chacha_block(cm_key, cm_nnc, cm_ctr);
                ld_ctr_q.push_back(cm_ctr);
                cm_dly  <= $urandom_range(1, 6);
            end else if (cm_dly > 0) begin
                cm_dly <= cm_dly - 1;
                if (cm_dly == 1) begin cm_ready <= 1'b1; rd_i <= 7'd0; end
            end

            if (cm_ready && core_rd_blk) begin
                cm_ready <= 1'b0; cm_rd <= 1'b1; rd_i <= 7'd1;
            end else if (cm_rd) begin
                rd_i <= rd_i + 7'd1;
                if (rd_i == 7'd63) cm_rd <= 1'b0;
            end

            // writes take priority: a new load aborts any block in flight
            if (core_wr_key | core_wr_nnc | core_wr_ctr) begin
                cm_ready <= 1'b0; cm_rd <= 1'b0; cm_pend <= 1'b0; cm_dly <= 0;
            end
        end
    end

    // ---------------- scoreboard ----------------
    logic [255:0] ref_key;
    logic [63:0]  ref_nnc, ref_ctr0;
    int           acc_cnt = 0;
    int           ref_base = 0;
    logic [7:0]   sb_q  [$];
    logic [7:0]   got_q [$];

    function automatic logic [7:0] ks_at(input int pos);
        logic [511:0] b;
        b = chacha_block(ref_key, ref_nnc, ref_ctr0 + 64'(pos / 64));
        return b[8*(pos % 64) +: 8];
    endfunction

    // stimulus side: an accepted plaintext byte fixes its expected ciphertext
    always @(negedge clk) begin
        if (rst_n && pt_valid && pt_ready) begin
            sb_q.push_back(pt_data ^ ks_at(acc_cnt - ref_base));
            acc_cnt <= acc_cnt + 1;
        end
    end

    // monitor: every ciphertext handshake is checked against the oldest expectation
    always @(negedge clk) begin
        if (rst_n && ct_valid && ct_ready) begin
            got_q.push_back(ct_data);
            if (sb_q.size() == 0) check("ct_unexpected", 64'(ct_data), 64'hxx);
            else                  check("ct_byte", 64'(ct_data), 64'(sb_q.pop_front()));
        end
    end

    // ---------------- downstream ready / pause driver ----------------
    logic rdy_rand = 1'b0, rdy_val = 1'b1, pause_rand = 1'b0;
    always @(posedge clk) begin
        #1;
        ct_ready = rdy_rand ? ($urandom_range(0, 3) != 0) : rdy_val;
        pause    = pause_rand ? 1'($urandom_range(0, 1)) : 1'b0;
    end

    // ---------------- tasks (enter and leave at posedge+1) ----------------
    task automatic pulse_start(input logic [255:0] k, input logic [63:0] n, input logic [63:0] c);
        ref_key = k; ref_nnc = n; ref_ctr0 = c; ref_base = acc_cnt;
        sb_q.delete(); got_q.delete(); ld_ctr_q.delete();
        key_in = k; nonce_in = n; ctr_in = c; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic load_trace(input logic [255:0] k, input logic [63:0] n, input logic [63:0] c);
        logic [7:0] eb;
        for (int i = 0; i < 48; i++) begin
            @(negedge clk);
            eb = (i < 32) ? k[8*i +: 8] : (i < 40) ? n[8*(i-32) +: 8] : c[8*(i-40) +: 8];
            check("trace_din",  64'(core_din), 64'(eb));
            check("trace_strb", 64'({core_wr_key, core_wr_nnc, core_wr_ctr}),
                  64'({i == 0, i == 32, i == 40}));
            check("trace_hold", 64'(core_hold), 64'(pause));
        end
        @(posedge clk); #1;
    endtask

    task automatic send(input logic [7:0] d, input int gap);
        int t;
        if (gap > 0) begin
            pt_valid = 1'b0;
            repeat (gap) @(posedge clk);
            #1;
        end
        pt_data = d; pt_valid = 1'b1; t = 0;
        @(negedge clk);
        while (!pt_ready && t < 3000) begin @(negedge clk); t++; end
        if (t >= 3000) check("pt_accept_timeout", 64'(t), 64'd0);
        @(posedge clk); #1;
        pt_valid = 1'b0;
    endtask

    task automatic send_stream(input int n, input int mode, input bit gaps);
        for (int i = 0; i < n; i++)
            send(mode == 0 ? 8'h00 : mode == 1 ? 8'hA5 : 8'($urandom), gaps ? $urandom_range(0, 2) : 0);
    endtask

    task automatic wait_drain();
        int t = 0;
        @(negedge clk);
        while ((sb_q.size() != 0 || ct_valid) && t < 5000) begin @(negedge clk); t++; end
        check("drain_pending", 64'(sb_q.size()), 64'd0);
        @(posedge clk); #1;
    endtask

    logic [7:0] zv0 [8] = '{8'h76, 8'hb8, 8'he0, 8'had, 8'ha0, 8'hf1, 8'h3d, 8'h90};
    logic [7:0] zv1 [8] = '{8'h9f, 8'h07, 8'he7, 8'hbe, 8'h55, 8'h51, 8'h38, 8'h7a};

    initial begin
        #(10 * 60000);
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [255:0] k;
        logic [63:0]  n, c;
        logic [7:0]   held;
        int           t;
        rst_n = 1'b0; start = 1'b0; key_in = '0; nonce_in = '0; ctr_in = '0;
        pt_data = 8'd0; pt_valid = 1'b0;

        // reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", 64'({pt_ready, ct_data, ct_valid, busy, ctr_wrap, core_wr_key,
              core_wr_nnc, core_wr_ctr, core_rd_blk, core_hold, core_din}), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // zero vector, two blocks
        pulse_start('0, '0, '0);
        load_trace('0, '0, '0);
        send_stream(128, 0, 1'b0);
        wait_drain();
        check("zv_count", 64'(got_q.size()), 64'd128);
        if (got_q.size() >= 128)
            for (int i = 0; i < 8; i++) begin
                check("zv_blk0", 64'(got_q[i]), 64'(zv0[i]));
                check("zv_blk1", 64'(got_q[64+i]), 64'(zv1[i]));
            end
        check("zv_second_ctr", ld_ctr_q.size() >= 2 ? ld_ctr_q[1] : 64'hdead, 64'd1);

        // random key material, random gaps, random backpressure and pause
        k = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        n = {$urandom, $urandom}; c = {$urandom, $urandom};
        pause_rand = 1'b1;
        pulse_start(k, n, c);
        load_trace(k, n, c);
        rdy_rand = 1'b1;
        send_stream(200, 2, 1'b1);
        wait_drain();
        rdy_rand = 1'b0; pause_rand = 1'b0;
        @(posedge clk); #1;

        // backpressure stall mid-drain
        k = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        pulse_start(k, 64'h0123_4567_89ab_cdef, 64'd5);
        fork
            send_stream(64, 1, 1'b0);
            begin
                t = 0;
                @(negedge clk);
                while (got_q.size() < 20 && t < 3000) begin @(negedge clk); t++; end
                check("stall_reach", 64'(t >= 3000), 64'd0);
                rdy_val = 1'b0;
                @(negedge clk);
                held = ct_data;
                check("stall_ct_valid", 64'(ct_valid), 64'd1);
                for (int i = 0; i < 10; i++) begin
                    check("stall_pt_ready", 64'(pt_ready), 64'd0);
                    check("stall_ct_data", 64'(ct_data), 64'(held));
                    @(negedge clk);
                end
                rdy_val = 1'b1;
            end
        join
        wait_drain();
        check("stall_count", 64'(got_q.size()), 64'd64);

        // counter wrap
        k = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        pulse_start(k, {$urandom, $urandom}, 64'hFFFF_FFFF_FFFF_FFFF);
        @(negedge clk);
        check("wrap_before", 64'(ctr_wrap), 64'd0);
        @(posedge clk); #1;
        send_stream(64, 2, 1'b1);
        wait_drain();
        check("wrap_set", 64'(ctr_wrap), 64'd1);
        t = 0;
        while (ld_ctr_q.size() < 2 && t < 500) begin @(negedge clk); t++; end
        check("wrap_next_ctr", ld_ctr_q.size() >= 2 ? ld_ctr_q[1] : 64'hdead, 64'd0);
        @(posedge clk); #1;

        // start clears ctr_wrap; abort mid-READ at capture 20
        k = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        pulse_start(k, 64'h1111_2222_3333_4444, 64'd9);
        @(negedge clk);
        check("wrap_cleared", 64'(ctr_wrap), 64'd0);
        t = 0;
        while (!core_rd_blk && t < 500) begin @(negedge clk); t++; end
        check("rd_blk_seen", 64'(core_rd_blk), 64'd1);
        repeat (20) @(posedge clk);
        #1;
        k = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        n = {$urandom, $urandom}; c = {$urandom, $urandom};
        pulse_start(k, n, c);
        load_trace(k, n, c);
        send_stream(64, 2, 1'b0);
        wait_drain();

        // reset mid-drain
        k = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        pulse_start(k, 64'h5, 64'h7);
        send_stream(30, 2, 1'b0);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("reset_mid_drain", 64'({pt_ready, ct_data, ct_valid, busy, ctr_wrap, core_wr_key,
              core_wr_nnc, core_wr_ctr, core_rd_blk, core_hold, core_din}), 64'd0);
        sb_q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_after_reset", 64'(busy), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
